wb_arbiter_2m: RTL and testbench



---
 rtl/wb_arbiter_2m.sv | 183 ++++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Round-robin two-master to one-slave pipelined Wishbone arbiter. Ownership is decided per CYC.
// Optional bus-hang abort is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_resetn,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    input  logic              i_m0_we,
    input  logic [SEL_W-1:0]  i_m0_sel,
    input  logic              i_m0_stb,
    input  logic              i_m0_cyc,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    input  logic              i_m1_we,
    input  logic [SEL_W-1:0]  i_m1_sel,
    input  logic              i_m1_stb,
    input  logic              i_m1_cyc,
    output logic [DATA_W-1:0] o_m0_data,
    output logic              o_m0_ack,
    output logic              o_m0_stall,
    output logic              o_m0_err,
    output logic [DATA_W-1:0] o_m1_data,
    output logic              o_m1_ack,
    output logic              o_m1_stall,
    output logic              o_m1_err,
    output logic [ADDR_W-1:0] o_wb_m2s_addr,
    output logic [DATA_W-1:0] o_wb_m2s_data,
    output logic              o_wb_m2s_we,
    output logic [SEL_W-1:0]  o_wb_m2s_sel,
    output logic              o_wb_m2s_stb,
    output logic              o_wb_m2s_cyc,
    input  logic [DATA_W-1:0] i_wb_s2m_data,
    input  logic              i_wb_s2m_ack,
    input  logic              i_wb_s2m_stall,
    input  logic              i_wb_s2m_err,
    output logic [1:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_ptr;       // 0: m0 wins a tie, 1: m1 wins a tie
    logic   w_next_ptr;
    logic   w_tmo;

    // State and round-robin pointer register
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    // Arbitration and release decisions
    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || !r_ptr)) begin
                    w_next_state = ST_GNT0;
                end else if (i_m1_cyc) begin
                    w_next_state = ST_GNT1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!i_m0_cyc || w_tmo) begin
                    w_next_state = ST_IDLE;
                    w_next_ptr   = 1'b1;
                end else begin
                    w_next_state = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!i_m1_cyc || w_tmo) begin
                    w_next_state = ST_IDLE;
                    w_next_ptr   = 1'b0;
                end else begin
                    w_next_state = ST_GNT1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request/response steering from the registered owner
    always_comb begin
        o_wb_m2s_addr = '0;
        o_wb_m2s_data = '0;
        o_wb_m2s_we   = 1'b0;
        o_wb_m2s_sel  = '0;
        o_wb_m2s_stb  = 1'b0;
        o_wb_m2s_cyc  = 1'b0;
        o_m0_ack      = 1'b0;
        o_m0_err      = 1'b0;
        o_m0_stall    = 1'b1;
        o_m1_ack      = 1'b0;
        o_m1_err      = 1'b0;
        o_m1_stall    = 1'b1;
        o_grant       = 2'b00;
        case (r_state)
            ST_GNT0: begin
                o_wb_m2s_addr = i_m0_addr;
                o_wb_m2s_data = i_m0_data;
                o_wb_m2s_we   = i_m0_we;
                o_wb_m2s_sel  = i_m0_sel;
                o_wb_m2s_stb  = i_m0_stb & i_m0_cyc & ~w_tmo;
                o_wb_m2s_cyc  = i_m0_cyc & ~w_tmo;
                o_m0_ack      = i_wb_s2m_ack;
                o_m0_err      = i_wb_s2m_err | w_tmo;
                o_m0_stall    = i_wb_s2m_stall;
                o_grant       = 2'b01;
            end
            ST_GNT1: begin
                o_wb_m2s_addr = i_m1_addr;
                o_wb_m2s_data = i_m1_data;
                o_wb_m2s_we   = i_m1_we;
                o_wb_m2s_sel  = i_m1_sel;
                o_wb_m2s_stb  = i_m1_stb & i_m1_cyc & ~w_tmo;
                o_wb_m2s_cyc  = i_m1_cyc & ~w_tmo;
                o_m1_ack      = i_wb_s2m_ack;
                o_m1_err      = i_wb_s2m_err | w_tmo;
                o_m1_stall    = i_wb_s2m_stall;
                o_grant       = 2'b10;
            end
            default: begin
                o_grant       = 2'b00;
            end
        endcase
    end

    assign o_m0_data = i_wb_s2m_data;
    assign o_m1_data = i_wb_s2m_data;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds silent cycles already elapsed; abort on the cycle that would make it TIMEOUT_CYCLES
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_granted;

    assign w_granted = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    assign w_tmo     = w_granted && !i_wb_s2m_ack && !i_wb_s2m_err && (r_tmo_cnt == CNT_LAST);
    assign o_timeout = w_tmo;

    // Silent-cycle counter, restarted by IDLE, any response, or an abort
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_tmo_cnt <= '0;
        end else if (!w_granted || i_wb_s2m_ack || i_wb_s2m_err || w_tmo) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_tmo_cfg;

    assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign w_tmo            = 1'b0;
    assign o_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m; the abort sequence is checked
// when WB_ARB_TIMEOUT_EN is defined, otherwise the indefinite hold is checked.
module tb_wb_arbiter_2m;

    logic        clk = 1'b0;
    logic        i_resetn;
    logic [31:0] i_m0_addr, i_m1_addr, i_m0_data, i_m1_data;
    logic        i_m0_we, i_m1_we, i_m0_stb, i_m1_stb, i_m0_cyc, i_m1_cyc;
    logic [3:0]  i_m0_sel, i_m1_sel;
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_m0_ack, o_m0_stall, o_m0_err, o_m1_ack, o_m1_stall, o_m1_err;
    logic [31:0] o_wb_m2s_addr, o_wb_m2s_data;
    logic        o_wb_m2s_we, o_wb_m2s_stb, o_wb_m2s_cyc;
    logic [3:0]  o_wb_m2s_sel;
    logic [31:0] i_wb_s2m_data;
    logic        i_wb_s2m_ack, i_wb_s2m_stall, i_wb_s2m_err;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .i_resetn(i_resetn),
        .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_we(i_m0_we), .i_m0_sel(i_m0_sel),
        .i_m0_stb(i_m0_stb), .i_m0_cyc(i_m0_cyc),
        .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_we(i_m1_we), .i_m1_sel(i_m1_sel),
        .i_m1_stb(i_m1_stb), .i_m1_cyc(i_m1_cyc),
        .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err),
        .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err),
        .o_wb_m2s_addr(o_wb_m2s_addr), .o_wb_m2s_data(o_wb_m2s_data), .o_wb_m2s_we(o_wb_m2s_we),
        .o_wb_m2s_sel(o_wb_m2s_sel), .o_wb_m2s_stb(o_wb_m2s_stb), .o_wb_m2s_cyc(o_wb_m2s_cyc),
        .i_wb_s2m_data(i_wb_s2m_data), .i_wb_s2m_ack(i_wb_s2m_ack),
        .i_wb_s2m_stall(i_wb_s2m_stall), .i_wb_s2m_err(i_wb_s2m_err),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next active edge; inputs are then driven mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        i_m0_addr = 32'h0; i_m0_data = 32'h0; i_m0_we = 1'b0; i_m0_sel = 4'h0;
        i_m0_stb = 1'b0; i_m0_cyc = 1'b0;
        i_m1_addr = 32'h0; i_m1_data = 32'h0; i_m1_we = 1'b0; i_m1_sel = 4'h0;
        i_m1_stb = 1'b0; i_m1_cyc = 1'b0;
        i_wb_s2m_data = 32'h0; i_wb_s2m_ack = 1'b0; i_wb_s2m_stall = 1'b0; i_wb_s2m_err = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_resetn = 1'b0;
        step();
        step();
        i_resetn = 1'b1;
        step();
    endtask

    logic [1:0] exp_gnt;

    initial begin
        i_resetn = 1'b0;
        idle_inputs();
        do_reset();
        settle();
        check("rst_grant", o_grant, 2'b00);
        check("rst_m0_stall", o_m0_stall, 1'b1);
        check("rst_m1_stall", o_m1_stall, 1'b1);
        check("rst_slave_cyc", o_wb_m2s_cyc, 1'b0);
        check("rst_timeout", o_timeout, 1'b0);

        // Single m0 write
        i_m0_addr = 32'h8000_0000; i_m0_data = 32'h0000_002A; i_m0_we = 1'b1;
        i_m0_sel = 4'hF; i_m0_stb = 1'b1; i_m0_cyc = 1'b1;
        i_wb_s2m_data = 32'hDEAD_BEEF;
        settle();
        check("req_cycle_grant", o_grant, 2'b00);
        check("req_cycle_stall", o_m0_stall, 1'b1);
        check("bcast_m0_data", o_m0_data, 32'hDEAD_BEEF);
        check("bcast_m1_data", o_m1_data, 32'hDEAD_BEEF);
        step();
        settle();
        check("wr_grant", o_grant, 2'b01);
        check("wr_addr", o_wb_m2s_addr, 32'h8000_0000);
        check("wr_data", o_wb_m2s_data, 32'h0000_002A);
        check("wr_we", o_wb_m2s_we, 1'b1);
        check("wr_sel", o_wb_m2s_sel, 4'hF);
        check("wr_stb", o_wb_m2s_stb, 1'b1);
        check("wr_cyc", o_wb_m2s_cyc, 1'b1);
        check("wr_m0_stall", o_m0_stall, 1'b0);
        check("wr_m1_stall", o_m1_stall, 1'b1);
        i_m0_stb = 1'b0;
        i_wb_s2m_ack = 1'b1;
        settle();
        check("wr_m0_ack", o_m0_ack, 1'b1);
        check("wr_m1_ack", o_m1_ack, 1'b0);
        step();
        i_wb_s2m_ack = 1'b0;
        i_m0_cyc = 1'b0;
        settle();
        check("rel_slave_cyc_comb", o_wb_m2s_cyc, 1'b0);
        step();
        settle();
        check("rel_grant", o_grant, 2'b00);

        // Contention straight after reset: m0 first, one idle cycle, then m1
        do_reset();
        i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
        step();
        settle();
        check("cont_first", o_grant, 2'b01);
        i_wb_s2m_ack = 1'b1;
        settle();
        check("cont_m1_ack_masked", o_m1_ack, 1'b0);
        check("cont_m1_stall", o_m1_stall, 1'b1);
        i_wb_s2m_ack = 1'b0;
        i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
        step();
        settle();
        check("cont_idle_gap", o_grant, 2'b00);
        step();
        settle();
        check("cont_second", o_grant, 2'b10);

        // Fairness: both keep requesting, owner drops cyc for one cycle after each beat
        do_reset();
        i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
        step();
        exp_gnt = 2'b01;
        for (int k = 0; k < 8; k++) begin
            settle();
            check($sformatf("fair_grant_%0d", k), o_grant, exp_gnt);
            if (exp_gnt == 2'b01) begin
                i_m0_cyc = 1'b0;
            end else begin
                i_m1_cyc = 1'b0;
            end
            step();
            settle();
            check($sformatf("fair_idle_%0d", k), o_grant, 2'b00);
            i_m0_cyc = 1'b1;
            i_m1_cyc = 1'b1;
            step();
            exp_gnt = (exp_gnt == 2'b01) ? 2'b10 : 2'b01;
        end
        i_m0_cyc = 1'b0; i_m1_cyc = 1'b0;

        // Error pass-through on an m1 read, grant held until m1 drops cyc
        do_reset();
        i_m1_addr = 32'h0000_0100; i_m1_we = 1'b0; i_m1_sel = 4'hF;
        i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
        step();
        settle();
        check("err_grant", o_grant, 2'b10);
        check("err_addr", o_wb_m2s_addr, 32'h0000_0100);
        check("err_we", o_wb_m2s_we, 1'b0);
        i_m1_stb = 1'b0;
        i_wb_s2m_err = 1'b1;
        settle();
        check("err_m1_err", o_m1_err, 1'b1);
        check("err_m0_err", o_m0_err, 1'b0);
        step();
        i_wb_s2m_err = 1'b0;
        step();
        step();
        settle();
        check("err_hold", o_grant, 2'b10);
        i_m1_cyc = 1'b0;
        step();
        settle();
        check("err_release", o_grant, 2'b00);

        // Silent slave on an m0 request
        do_reset();
        i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
        step();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            settle();
            check($sformatf("tmo_quiet_%0d", k), {o_timeout, o_m0_err, o_grant}, 4'b0001);
            step();
        end
        settle();
        check("tmo_pulse", o_timeout, 1'b1);
        check("tmo_m0_err", o_m0_err, 1'b1);
        check("tmo_m1_err", o_m1_err, 1'b0);
        check("tmo_slave_cyc", o_wb_m2s_cyc, 1'b0);
        check("tmo_slave_stb", o_wb_m2s_stb, 1'b0);
        step();
        settle();
        check("tmo_idle", o_grant, 2'b00);
        check("tmo_pulse_end", o_timeout, 1'b0);
        i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
`else
        for (int k = 0; k < 100; k++) begin
            step();
        end
        settle();
        check("hold_grant", o_grant, 2'b01);
        check("hold_timeout", o_timeout, 1'b0);
        check("hold_m0_err", o_m0_err, 1'b0);
        check("hold_slave_cyc", o_wb_m2s_cyc, 1'b1);
        i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
`endif
        step();

        // Asynchronous reset in the middle of a granted m0 cycle
        do_reset();
        i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
        step();
        i_wb_s2m_ack = 1'b1;
        settle();
        check("arst_pre_cyc", o_wb_m2s_cyc, 1'b1);
        check("arst_pre_ack", o_m0_ack, 1'b1);
        i_resetn = 1'b0;
        settle();
        check("arst_cyc", o_wb_m2s_cyc, 1'b0);
        check("arst_stb", o_wb_m2s_stb, 1'b0);
        check("arst_grant", o_grant, 2'b00);
        check("arst_m0_stall", o_m0_stall, 1'b1);
        check("arst_m1_stall", o_m1_stall, 1'b1);
        check("arst_m0_ack", o_m0_ack, 1'b0);
        i_resetn = 1'b1;
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
